// File: rtl/conv_sequencer.sv
// Convolution initiator: holds a kernel and a pixel window, issues one row per multiply pass
// to the matrix accelerator, then requests the final accumulate and hands the sum to the host.
module conv_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned REST_ADDR      = KERNEL_SIZE * KERNEL_SIZE,
  parameter int unsigned ADDR_WIDTH     = $clog2(REST_ADDR),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              wr_en,
  input  logic                              wr_sel,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              start,
  output logic                              busy,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] multiplier_input,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] multiplicand_input,
  output logic [KERNEL_SIZE-1:0]            mStart,
  input  logic [KERNEL_SIZE-1:0]            mReady,
  output logic                              finalAdd,
  input  logic [2*DATA_WIDTH-1:0]           finalAccumulate,
  input  logic                              finalReady,
  output logic [2*DATA_WIDTH-1:0]           result,
  output logic                              result_valid,
  input  logic                              result_ready,
  output logic                              error
);

  localparam int unsigned ROW_WIDTH = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int unsigned TMO_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LANE_BITS = KERNEL_SIZE * DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_MUL, FINAL, WAIT_FINAL, DONE} state_t;

  state_t                  state, stateNext;
  logic [ROW_WIDTH-1:0]    row, rowNext;
  logic [KERNEL_SIZE-1:0]  mask, maskNext, mStartNext;
  logic [TMO_WIDTH-1:0]    tmo, tmoNext;
  logic                    errorNext, resultValidNext, finalAddNext, busyNext;
  logic [2*DATA_WIDTH-1:0] resultNext;
  logic [LANE_BITS-1:0]    mulNext, mcdNext;
  logic                    allReady, tmoExpired;

  logic [DATA_WIDTH-1:0] kernelMem [REST_ADDR];
  logic [DATA_WIDTH-1:0] windowMem [REST_ADDR];

  assign allReady   = &(mask | mReady);
  assign tmoExpired = (tmo == TMO_WIDTH'(TIMEOUT_CYCLES - 1));

  // Host load port; only honoured while idle and inside the bank.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < REST_ADDR; i++) begin
        kernelMem[i] <= '0;
        windowMem[i] <= '0;
      end
    end else if (wr_en && (state == IDLE) && (32'(wr_addr) < REST_ADDR)) begin
      if (wr_sel) windowMem[wr_addr] <= wr_data;
      else        kernelMem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state              <= IDLE;
      row                <= '0;
      mask               <= '0;
      tmo                <= '0;
      busy               <= 1'b0;
      mStart             <= '0;
      finalAdd           <= 1'b0;
      multiplier_input   <= '0;
      multiplicand_input <= '0;
      result             <= '0;
      result_valid       <= 1'b0;
      error              <= 1'b0;
    end else begin
      state              <= stateNext;
      row                <= rowNext;
      mask               <= maskNext;
      tmo                <= tmoNext;
      busy               <= busyNext;
      mStart             <= mStartNext;
      finalAdd           <= finalAddNext;
      multiplier_input   <= mulNext;
      multiplicand_input <= mcdNext;
      result             <= resultNext;
      result_valid       <= resultValidNext;
      error              <= errorNext;
    end
  end

  always_comb begin
    stateNext       = state;
    rowNext         = row;
    maskNext        = mask;
    tmoNext         = tmo;
    errorNext       = error;
    resultNext      = result;
    resultValidNext = result_valid;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = ISSUE;
          rowNext   = '0;
          errorNext = 1'b0;
        end
      end
      ISSUE: begin
        maskNext  = '0;
        tmoNext   = '0;
        stateNext = WAIT_MUL;
      end
      WAIT_MUL: begin
        maskNext = mask | mReady;
        if (allReady) begin
          if (row == ROW_WIDTH'(KERNEL_SIZE - 1)) begin
            stateNext = FINAL;
          end else begin
            rowNext   = row + ROW_WIDTH'(1);
            stateNext = ISSUE;
          end
        end else if (tmoExpired) begin
          errorNext = 1'b1;
          stateNext = IDLE;
        end else begin
          tmoNext = tmo + TMO_WIDTH'(1);
        end
      end
      FINAL: begin
        tmoNext   = '0;
        stateNext = WAIT_FINAL;
      end
      WAIT_FINAL: begin
        if (finalReady) begin
          resultNext      = finalAccumulate;
          resultValidNext = 1'b1;
          stateNext       = DONE;
        end else if (tmoExpired) begin
          errorNext = 1'b1;
          stateNext = IDLE;
        end else begin
          tmoNext = tmo + TMO_WIDTH'(1);
        end
      end
      DONE: begin
        if (result_ready) begin
          resultValidNext = 1'b0;
          stateNext       = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Outputs are registered from the upcoming state so they line up with it.
    busyNext     = (stateNext != IDLE);
    mStartNext   = (stateNext == ISSUE) ? '1 : '0;
    finalAddNext = (stateNext == FINAL);
    mulNext      = '0;
    mcdNext      = '0;
    if (stateNext == WAIT_MUL) begin
      mulNext = multiplier_input;
      mcdNext = multiplicand_input;
    end else if (stateNext == ISSUE) begin
      for (int unsigned j = 0; j < KERNEL_SIZE; j++) begin
        mulNext[j*DATA_WIDTH +: DATA_WIDTH] =
          kernelMem[ADDR_WIDTH'(32'(rowNext) * KERNEL_SIZE + j)];
        mcdNext[j*DATA_WIDTH +: DATA_WIDTH] =
          windowMem[ADDR_WIDTH'(32'(rowNext) * KERNEL_SIZE + j)];
      end
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: a behavioural accelerator responds to the DUT while a
// monitor checks issued rows, pass spacing, operand stability and returned results.
module tb_conv_sequencer;

  localparam int unsigned DW    = 32;
  localparam int unsigned K     = 3;
  localparam int unsigned N     = K * K;
  localparam int unsigned AW    = $clog2(N);
  localparam int unsigned TMO   = 16;
  localparam int          NEVER = 1 << 30;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              wr_en, wr_sel, start, finalReady, result_ready;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              busy, finalAdd, result_valid, error;
  logic [K*DW-1:0]   multiplier_input, multiplicand_input;
  logic [K-1:0]      mStart, mReady;
  logic [2*DW-1:0]   finalAccumulate, result;

  conv_sequencer #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .REST_ADDR(N), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .multiplier_input(multiplier_input),
    .multiplicand_input(multiplicand_input), .mStart(mStart), .mReady(mReady),
    .finalAdd(finalAdd), .finalAccumulate(finalAccumulate), .finalReady(finalReady),
    .result(result), .result_valid(result_valid), .result_ready(result_ready), .error(error)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Reference state: bank contents as the host believes them, and responder timing per row.
  logic [DW-1:0] kM [N];
  logic [DW-1:0] wM [N];
  int            dly [K][K];
  int            fDly;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [K*DW-1:0] mul; logic [K*DW-1:0] mcd; int gap; } rowExp_t;
  typedef struct { logic [63:0] val; int lat; } resExp_t;
  rowExp_t rowQ[$];
  resExp_t resQ[$];

  int          startCyc;
  int          issueCyc [K];
  int          rIdx = K;
  logic [63:0] respSum = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Behavioural accelerator: per-lane pulses dly cycles after mStart, sum of observed products.
  initial begin
    int mrCnt;
    int fCnt;
    mrCnt = NEVER;
    fCnt  = NEVER;
    mReady = '0;
    finalReady = 1'b0;
    finalAccumulate = '0;
    forever begin
      @(posedge Clk);
      #1;
      if (!Rst) begin
        mReady = '0;
        finalReady = 1'b0;
        mrCnt = NEVER;
        fCnt = NEVER;
      end else begin
        if (mStart == '1) begin
          rIdx++;
          if (rIdx >= 0 && rIdx < K) issueCyc[rIdx] = cyc;
          mrCnt = 0;
          for (int j = 0; j < K; j++)
            respSum += 64'(multiplier_input[j*DW +: DW]) * 64'(multiplicand_input[j*DW +: DW]);
        end else if (mrCnt < NEVER) begin
          mrCnt++;
        end
        for (int j = 0; j < K; j++) begin
          mReady[j] = 1'b0;
          if (rIdx >= 0 && rIdx < K) mReady[j] = (mrCnt == dly[rIdx][j]);
        end
        if (finalAdd) fCnt = 0;
        else if (fCnt < NEVER) fCnt++;
        finalReady = (fCnt == fDly);
        finalAccumulate = finalReady ? respSum : {$urandom, $urandom};
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues a row or presents a result.
  initial begin
    logic [K*DW-1:0] hMul, hMcd;
    bit      inRow;
    bit      prevRv;
    int      lastIssue;
    rowExp_t re;
    resExp_t rs;
    inRow = 0;
    prevRv = 0;
    lastIssue = 0;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        inRow = 0;
        prevRv = 0;
      end else begin
        if (mStart == '1) begin
          if (rowQ.size() == 0) begin
            failNow("unexpected_mStart");
          end else begin
            re = rowQ.pop_front();
            chk("row_multiplier", 128'(multiplier_input), 128'(re.mul));
            chk("row_multiplicand", 128'(multiplicand_input), 128'(re.mcd));
            if (re.gap > 0) chk("issue_gap", 128'(cyc - lastIssue), 128'(re.gap));
          end
          lastIssue = cyc;
          hMul = multiplier_input;
          hMcd = multiplicand_input;
          inRow = 1;
        end else if (mStart != '0) begin
          failNow("partial_mStart");
        end else if (inRow) begin
          if (finalAdd || !busy) begin
            inRow = 0;
          end else begin
            chk("stable_multiplier", 128'(multiplier_input), 128'(hMul));
            chk("stable_multiplicand", 128'(multiplicand_input), 128'(hMcd));
          end
        end
        if (result_valid && !prevRv) begin
          if (resQ.size() == 0) begin
            failNow("unexpected_result_valid");
          end else begin
            rs = resQ.pop_front();
            chk("result", 128'(result), 128'(rs.val));
            chk("latency", 128'(cyc - startCyc), 128'(rs.lat));
          end
        end
        prevRv = result_valid;
      end
    end
  end

  task automatic setDly(input int a, input int b, input int c);
    for (int r = 0; r < K; r++) begin
      dly[r][0] = a;
      dly[r][1] = b;
      dly[r][2] = c;
    end
  endtask

  task automatic wr(input bit sel, input int addr, input logic [DW-1:0] data);
    @(posedge Clk);
    #1;
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = AW'(addr);
    wr_data = data;
    if (addr < N) begin
      if (sel) wM[addr] = data;
      else     kM[addr] = data;
    end
    @(posedge Clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Expected rows: bank word r*K+j on lane j; next pass starts once the slowest lane is back.
  task automatic pushRows(input int nRows);
    rowExp_t re;
    int prevMax;
    prevMax = 0;
    for (int r = 0; r < nRows; r++) begin
      for (int j = 0; j < K; j++) begin
        re.mul[j*DW +: DW] = kM[r*K + j];
        re.mcd[j*DW +: DW] = wM[r*K + j];
      end
      re.gap = (r == 0) ? 0 : 1 + prevMax;
      rowQ.push_back(re);
      prevMax = 0;
      for (int j = 0; j < K; j++) if (dly[r][j] > prevMax) prevMax = dly[r][j];
    end
  endtask

  task automatic pulseStart();
    rIdx = -1;
    respSum = '0;
    @(posedge Clk);
    #1;
    start = 1'b1;
    startCyc = cyc;
    @(posedge Clk);
    #1;
    start = 1'b0;
  endtask

  task automatic runConv(input int hold, input bit tryIgnored);
    resExp_t rs;
    logic [63:0] s;
    int lat;
    int mx;
    int t;
    s = '0;
    for (int i = 0; i < N; i++) s += 64'(kM[i]) * 64'(wM[i]);
    // One cycle to sample start, each pass is issue + slowest lane, then final + its response.
    lat = 2 + fDly;
    for (int r = 0; r < K; r++) begin
      mx = 0;
      for (int j = 0; j < K; j++) if (dly[r][j] > mx) mx = dly[r][j];
      lat += 1 + mx;
    end
    rs.val = s;
    rs.lat = lat;
    pushRows(K);
    resQ.push_back(rs);
    pulseStart();
    @(negedge Clk);
    chk("error_after_start", 128'(error), 128'(0));
    chk("busy_after_start", 128'(busy), 128'(1));
    t = 0;
    while (!result_valid && t < 500) begin
      @(negedge Clk);
      t++;
    end
    if (!result_valid) begin
      failNow("result_valid_timeout");
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk);
      #1;
      if (tryIgnored) begin
        start = (i % 3 == 0);
        wr_en = 1'b1;
        wr_sel = 1'(i);
        wr_addr = AW'($urandom_range(0, N - 1));
        wr_data = $urandom;
      end
      @(negedge Clk);
      chk("hold_valid", 128'(result_valid), 128'(1));
      chk("hold_result", 128'(result), 128'(s));
    end
    @(posedge Clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
    result_ready = 1'b1;
    @(posedge Clk);
    #1;
    result_ready = 1'b0;
    @(negedge Clk);
    chk("accept_valid_low", 128'(result_valid), 128'(0));
    chk("accept_idle", 128'(busy), 128'(0));
    chk("accept_result_held", 128'(result), 128'(s));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    Rst = 1'b0;
    wr_en = 1'b0;
    wr_sel = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    result_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      kM[i] = '0;
      wM[i] = '0;
    end
    setDly(1, 1, 1);
    fDly = 1;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_mStart", 128'(mStart), 128'(0));
    chk("reset_finalAdd", 128'(finalAdd), 128'(0));
    chk("reset_operands", 128'({multiplier_input, multiplicand_input}), 128'(0));
    chk("reset_result", 128'({result, result_valid, error}), 128'(0));
    @(negedge Clk);
    Rst = 1'b1;

    // Kernel 1..9 against a window of 2s: sum 90, nine-cycle latency.
    for (int i = 0; i < N; i++) wr(1'b0, i, DW'(i + 1));
    for (int i = 0; i < N; i++) wr(1'b1, i, DW'(2));
    runConv(2, 1'b0);

    // Staggered lanes: next pass waits for the slowest lane.
    setDly(1, 4, 2);
    runConv(3, 1'b0);

    // Result held while host stalls; start and writes during the stall are ignored.
    setDly(1, 1, 1);
    runConv(20, 1'b1);
    runConv(1, 1'b0);

    // Out-of-bank addresses leave storage alone.
    wr(1'b0, 9, 32'hDEAD_BEEF);
    wr(1'b1, 15, 32'hCAFE_F00D);
    runConv(0, 1'b0);

    // Lane 2 never answers on row 1: abort after TMO waiting cycles.
    setDly(1, 1, 1);
    dly[1][2] = NEVER;
    pushRows(2);
    pulseStart();
    t = 0;
    while (busy && t < 200) begin
      @(negedge Clk);
      t++;
    end
    chk("timeout_cycles", 128'(cyc - issueCyc[1]), 128'(TMO + 1));
    chk("timeout_error", 128'(error), 128'(1));
    chk("timeout_no_valid", 128'(result_valid), 128'(0));
    repeat (3) @(negedge Clk);
    chk("timeout_error_sticky", 128'(error), 128'(1));
    setDly(1, 1, 1);
    runConv(1, 1'b0);

    // Asynchronous reset during the second pass.
    dly[1][1] = 20;
    pushRows(2);
    pulseStart();
    t = 0;
    while (rIdx < 1 && t < 100) begin
      @(negedge Clk);
      t++;
    end
    repeat (3) @(negedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_pulses", 128'({mStart, finalAdd}), 128'(0));
    chk("midrst_operands", 128'({multiplier_input, multiplicand_input}), 128'(0));
    chk("midrst_result", 128'({result, result_valid, error}), 128'(0));
    rowQ.delete();
    resQ.delete();
    for (int i = 0; i < N; i++) begin
      kM[i] = '0;
      wM[i] = '0;
    end
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    setDly(1, 1, 1);
    runConv(1, 1'b0);
    for (int i = 0; i < N; i++) wr(1'b0, i, $urandom);
    for (int i = 0; i < N; i++) wr(1'b1, i, $urandom);
    runConv(1, 1'b0);

    // Randomized operands and responder timing.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) wr(1'b0, i, $urandom);
      for (int i = 0; i < N; i++) wr(1'b1, i, $urandom);
      for (int r = 0; r < K; r++)
        for (int j = 0; j < K; j++) dly[r][j] = $urandom_range(1, 4);
      fDly = $urandom_range(1, 3);
      runConv($urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(negedge Clk);
    if (rowQ.size() != 0 || resQ.size() != 0) failNow("scoreboard_not_drained");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
